// File: rtl/sd_cmd_phy.sv
// sd_cmd_phy: SD CMD-line engine. Sends one 48-bit command frame, captures
// and checks a short or long response, and retries on line errors.
module sd_cmd_phy #(
    parameter int NCR_MAX = 64,
    parameter int RETRIES = 2,
    parameter int GAP     = 8
) (
    input  logic         iclk,
    input  logic         irst,
    input  logic         istrobe,
    input  logic         istart,
    input  logic [5:0]   iindex,
    input  logic [31:0]  iarg,
    input  logic [1:0]   iresp_type,
    input  logic         icmd_sd,
    output logic         ocmd_sd,
    output logic         ocmd_oe,
    output logic         obusy,
    output logic         odone,
    output logic         ook,
    output logic         otimeout,
    output logic         ocrc_err,
    output logic [127:0] oresp,
    output logic [5:0]   oresp_index
);

    localparam int C0 = (NCR_MAX > 136) ? NCR_MAX : 136;
    localparam int C1 = (GAP > C0) ? GAP : C0;
    localparam int CW = $clog2(C1 + 1);
    localparam int AW = $clog2(RETRIES + 1) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT,
        S_RECV,
        S_CHECK,
        S_GAP
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [AW-1:0] r_attempt;
    logic [1:0]    r_type;
    logic [47:0]   r_frame;
    logic [47:0]   r_tx;
    logic [127:0]  r_shift;
    logic          r_fail;
    logic          r_att_to;
    logic          r_cmd;
    logic          r_oe;
    logic          r_done;
    logic          r_ok;
    logic          r_to;
    logic          r_crc;
    logic [127:0]  r_resp;
    logic [5:0]    r_resp_idx;

    logic [39:0]   w_tx_hdr;
    logic [6:0]    w_tx_crc;
    logic [6:0]    w_rx_crc;
    logic          w_pass;
    logic [CW-1:0] w_rx_last;
    logic          w_accept;
    logic          w_tx_bit;
    logic          w_tx_end;
    logic          w_rx_start;
    logic          w_wait_to;
    logic          w_rx_bit;
    logic          w_gap_end;
    logic          w_retry;

    function automatic logic [6:0] f_crc7(input logic [6:0] c, input logic b);
        logic w_fb;
        w_fb = b ^ c[6];
        return {c[5:0], 1'b0} ^ (w_fb ? 7'h09 : 7'h00);
    endfunction

    always_comb begin
        w_tx_hdr = {2'b01, iindex, iarg};
        w_tx_crc = '0;
        for (int i = 39; i >= 0; i--)
            w_tx_crc = f_crc7(w_tx_crc, w_tx_hdr[i]);
    end

    // Short frames sit in r_shift[47:0]; long frames lose their top 8 bits
    always_comb begin
        w_rx_crc = '0;
        for (int i = 127; i >= 8; i--)
            if (r_type == 2'd3 || i <= 47)
                w_rx_crc = f_crc7(w_rx_crc, r_shift[i]);
    end

    always_comb begin
        w_pass = 1'b1;
        unique case (r_type)
            2'd0: w_pass = 1'b1;
            2'd1: w_pass = r_shift[0] && (w_rx_crc == r_shift[7:1])
                           && (r_shift[45:40] == r_frame[45:40]);
            2'd2: w_pass = r_shift[0];
            2'd3: w_pass = r_shift[0] && (w_rx_crc == r_shift[7:1]);
        endcase
    end

    assign w_rx_last = (r_type == 2'd3) ? CW'(135) : CW'(47);

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_tx_bit    = 1'b0;
        w_tx_end    = 1'b0;
        w_rx_start  = 1'b0;
        w_wait_to   = 1'b0;
        w_rx_bit    = 1'b0;
        w_gap_end   = 1'b0;
        w_retry     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (istart) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                if (istrobe) begin
                    if (r_cnt == CW'(48)) begin
                        w_tx_end    = 1'b1;
                        w_state_nxt = (r_type == 2'd0) ? S_GAP : S_WAIT;
                    end else begin
                        w_tx_bit = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (istrobe) begin
                    if (!icmd_sd) begin
                        w_rx_start  = 1'b1;
                        w_state_nxt = S_RECV;
                    end else if (r_cnt == CW'(NCR_MAX - 1)) begin
                        w_wait_to   = 1'b1;
                        w_state_nxt = S_GAP;
                    end
                end
            end
            S_RECV: begin
                if (istrobe) begin
                    w_rx_bit = 1'b1;
                    if (r_cnt == w_rx_last)
                        w_state_nxt = S_CHECK;
                end
            end
            S_CHECK: w_state_nxt = S_GAP;
            S_GAP: begin
                if (istrobe && r_cnt == CW'(GAP - 1)) begin
                    w_gap_end = 1'b1;
                    if (r_fail && r_attempt < AW'(RETRIES)) begin
                        w_retry     = 1'b1;
                        w_state_nxt = S_SEND;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge iclk or posedge irst) begin
        if (irst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            r_cnt      <= '0;
            r_attempt  <= '0;
            r_type     <= '0;
            r_frame    <= '0;
            r_tx       <= '0;
            r_shift    <= '0;
            r_fail     <= 1'b0;
            r_att_to   <= 1'b0;
            r_cmd      <= 1'b1;
            r_oe       <= 1'b0;
            r_done     <= 1'b0;
            r_ok       <= 1'b0;
            r_to       <= 1'b0;
            r_crc      <= 1'b0;
            r_resp     <= '0;
            r_resp_idx <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_type    <= iresp_type;
                        r_frame   <= {w_tx_hdr, w_tx_crc, 1'b1};
                        r_tx      <= {w_tx_hdr, w_tx_crc, 1'b1};
                        r_cnt     <= '0;
                        r_attempt <= '0;
                        r_shift   <= '0;
                        r_fail    <= 1'b0;
                        r_att_to  <= 1'b0;
                        r_ok      <= 1'b0;
                        r_to      <= 1'b0;
                        r_crc     <= 1'b0;
                    end
                end
                S_SEND: begin
                    if (w_tx_bit) begin
                        r_cmd <= r_tx[47];
                        r_oe  <= 1'b1;
                        r_tx  <= {r_tx[46:0], 1'b1};
                        r_cnt <= r_cnt + CW'(1);
                    end else if (w_tx_end) begin
                        r_cmd <= 1'b1;
                        r_oe  <= 1'b0;
                        r_cnt <= '0;
                    end
                end
                S_WAIT: begin
                    if (w_rx_start) begin
                        r_shift <= {r_shift[126:0], icmd_sd};
                        r_cnt   <= CW'(1);
                    end else if (w_wait_to) begin
                        r_fail   <= 1'b1;
                        r_att_to <= 1'b1;
                        r_cnt    <= '0;
                    end else if (istrobe) begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_RECV: begin
                    if (w_rx_bit) begin
                        r_shift <= {r_shift[126:0], icmd_sd};
                        r_cnt   <= (r_cnt == w_rx_last) ? '0 : r_cnt + CW'(1);
                    end
                end
                S_CHECK: begin
                    r_fail   <= !w_pass;
                    r_att_to <= 1'b0;
                end
                S_GAP: begin
                    if (w_gap_end) begin
                        r_cnt <= '0;
                        if (w_retry) begin
                            r_attempt <= r_attempt + AW'(1);
                            r_tx      <= r_frame;
                        end else begin
                            r_done <= 1'b1;
                            r_ok   <= !r_fail;
                            r_to   <= r_fail && r_att_to;
                            r_crc  <= r_fail && !r_att_to;
                            unique case (r_type)
                                2'd0: begin
                                    r_resp     <= '0;
                                    r_resp_idx <= '0;
                                end
                                2'd1, 2'd2: begin
                                    r_resp     <= {96'b0, r_shift[39:8]};
                                    r_resp_idx <= r_shift[45:40];
                                end
                                2'd3: begin
                                    r_resp     <= {r_shift[127:1], 1'b0};
                                    r_resp_idx <= '0;
                                end
                            endcase
                        end
                    end else if (istrobe) begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign ocmd_sd     = r_cmd;
    assign ocmd_oe     = r_oe;
    assign obusy       = (r_state != S_IDLE);
    assign odone       = r_done;
    assign ook         = r_ok;
    assign otimeout    = r_to;
    assign ocrc_err    = r_crc;
    assign oresp       = r_resp;
    assign oresp_index = r_resp_idx;

endmodule

// File: tb/tb_sd_cmd_phy.sv
// tb_sd_cmd_phy: scoreboard bench for sd_cmd_phy with a simple card model
// answering on the CMD line under random SD-clock strobe spacing.
module tb_sd_cmd_phy;

    localparam int NCR_MAX = 64;
    localparam int RETRIES = 2;
    localparam int GAP     = 8;

    logic         iclk;
    logic         irst;
    logic         istrobe;
    logic         istart;
    logic [5:0]   iindex;
    logic [31:0]  iarg;
    logic [1:0]   iresp_type;
    logic         icmd_sd;
    logic         ocmd_sd;
    logic         ocmd_oe;
    logic         obusy;
    logic         odone;
    logic         ook;
    logic         otimeout;
    logic         ocrc_err;
    logic [127:0] oresp;
    logic [5:0]   oresp_index;

    sd_cmd_phy #(
        .NCR_MAX (NCR_MAX),
        .RETRIES (RETRIES),
        .GAP     (GAP)
    ) dut (
        .iclk        (iclk),
        .irst        (irst),
        .istrobe     (istrobe),
        .istart      (istart),
        .iindex      (iindex),
        .iarg        (iarg),
        .iresp_type  (iresp_type),
        .icmd_sd     (icmd_sd),
        .ocmd_sd     (ocmd_sd),
        .ocmd_oe     (ocmd_oe),
        .obusy       (obusy),
        .odone       (odone),
        .ook         (ook),
        .otimeout    (otimeout),
        .ocrc_err    (ocrc_err),
        .oresp       (oresp),
        .oresp_index (oresp_index)
    );

    typedef struct {
        logic [47:0]  frame;
        int           nfr;
        logic         ok;
        logic         to;
        logic         ce;
        logic         chk_resp;
        logic [127:0] resp;
        logic [5:0]   idx;
        int           rel;
    } exp_t;

    exp_t        sb[$];
    logic [47:0] txq[$];

    int total = 0;
    int bad   = 0;

    logic [47:0]  mon_sh;
    int           mon_bits;
    logic         prev_oe;
    int           since_rel;
    int           rel_count;

    logic [135:0] card_frame;
    int           card_len;
    int           card_from;
    int           card_delay;
    int           card_att;
    int           card_bits;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] crc7(input logic [119:0] d, input int n);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = n - 1; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    function automatic logic [47:0] mk_frame(input logic [5:0] idx,
                                             input logic [31:0] arg);
        logic [39:0] hdr;
        hdr = {2'b01, idx, arg};
        return {hdr, crc7({80'b0, hdr}, 40), 1'b1};
    endfunction

    task automatic wait_strobe();
        do @(posedge iclk); while (!istrobe);
        #1;
    endtask

    initial begin
        iclk = 1'b0;
        forever #5 iclk = ~iclk;
    end

    initial begin
        istrobe = 1'b0;
        forever begin
            @(negedge iclk);
            istrobe = ($urandom_range(0, 2) == 0);
        end
    end

    // Frame capture and strobe count since the CMD line was released
    initial begin
        mon_sh    = '0;
        mon_bits  = 0;
        prev_oe   = 1'b0;
        since_rel = 0;
        rel_count = 0;
        forever begin
            @(posedge iclk);
            #1;
            if (irst) begin
                mon_bits = 0;
                prev_oe  = 1'b0;
            end else if (istrobe) begin
                if (ocmd_oe) begin
                    mon_sh = {mon_sh[46:0], ocmd_sd};
                    mon_bits++;
                    if (mon_bits == 48) begin
                        txq.push_back(mon_sh);
                        mon_bits = 0;
                    end
                end
                if (prev_oe && !ocmd_oe) begin
                    since_rel = 0;
                    rel_count++;
                end else begin
                    since_rel++;
                end
                prev_oe = ocmd_oe;
            end
        end
    end

    initial begin
        icmd_sd = 1'b1;
        forever begin
            @(rel_count);
            card_att++;
            if (card_len > 0 && card_att >= card_from) begin
                repeat (card_delay) wait_strobe();
                for (int i = card_len - 1; i >= 0; i--) begin
                    icmd_sd = card_frame[i];
                    card_bits++;
                    wait_strobe();
                    if (irst) break;
                end
                icmd_sd = 1'b1;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic push_exp(input logic [47:0] fr, input int nfr,
                            input logic ok, input logic to, input logic ce,
                            input logic chk_resp, input logic [127:0] resp,
                            input logic [5:0] idx, input int rel);
        exp_t e;
        e.frame = fr;
        e.nfr = nfr;
        e.ok = ok;
        e.to = to;
        e.ce = ce;
        e.chk_resp = chk_resp;
        e.resp = resp;
        e.idx = idx;
        e.rel = rel;
        sb.push_back(e);
    endtask

    task automatic set_card(input logic [135:0] fr, input int len,
                            input int from, input int dly);
        card_frame = fr;
        card_len   = len;
        card_from  = from;
        card_delay = dly;
        card_att   = 0;
        card_bits  = 0;
    endtask

    task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg,
                           input logic [1:0] typ);
        int   n;
        exp_t e;
        @(posedge iclk);
        #1;
        iindex     = idx;
        iarg       = arg;
        iresp_type = typ;
        istart     = 1'b1;
        @(posedge iclk);
        #1;
        istart = 1'b0;
        check("busy_after_start", obusy, 1);
        check("flags_cleared", {ook, otimeout, ocrc_err}, 0);
        iindex = 6'd0;
        istart = 1'b1;
        @(posedge iclk);
        #1;
        istart = 1'b0;
        n = 0;
        while (1) begin
            @(posedge iclk);
            #2;
            if (odone) break;
            n++;
            if (n > 20000) break;
        end
        e = sb.pop_front();
        check("done_seen", odone, 1);
        if (!odone) begin
            txq.delete();
            return;
        end
        check("busy_fall", obusy, 0);
        check("ook", ook, e.ok);
        check("otimeout", otimeout, e.to);
        check("ocrc_err", ocrc_err, e.ce);
        check("nframes", txq.size(), e.nfr);
        foreach (txq[i]) check("frame", txq[i], e.frame);
        if (e.chk_resp) begin
            check("oresp", oresp, e.resp);
            check("oresp_index", oresp_index, e.idx);
        end
        if (e.rel >= 0) check("strobes_after_release", since_rel, e.rel);
        txq.delete();
        @(posedge iclk);
        #2;
        check("done_pulse", odone, 0);
        check("flags_hold", {ook, otimeout, ocrc_err}, {e.ok, e.to, e.ce});
    endtask

    task automatic chk_reset_outs(input string tag);
        check({tag, "_cmd"}, {ocmd_sd, ocmd_oe}, 2'b10);
        check({tag, "_busy_done"}, {obusy, odone}, 0);
        check({tag, "_flags"}, {ook, otimeout, ocrc_err}, 0);
        check({tag, "_resp"}, oresp, 0);
        check({tag, "_idx"}, oresp_index, 0);
    endtask

    logic [47:0]  f41;
    logic [47:0]  f2;
    logic [119:0] cid;
    logic [6:0]   cid_crc;
    logic [135:0] r2;

    initial begin
        int n;
        irst       = 1'b1;
        istart     = 1'b0;
        iindex     = '0;
        iarg       = '0;
        iresp_type = '0;
        set_card('0, 0, 1, 0);
        repeat (3) @(posedge iclk);
        #1;
        chk_reset_outs("reset");
        irst = 1'b0;
        repeat (2) @(posedge iclk);

        set_card('0, 0, 1, 0);
        push_exp(48'h400000000095, 1, 1, 0, 0, 1, '0, 6'd0, GAP);
        run_cmd(6'd0, 32'h0, 2'd0);

        set_card({88'b0, 48'h08000001AA13}, 48, 1, 5);
        push_exp(48'h48000001AA87, 1, 1, 0, 0, 1, 128'h1AA, 6'd8, -1);
        run_cmd(6'd8, 32'h1AA, 2'd1);

        set_card({88'b0, 48'h08000001AA15}, 48, 1, 5);
        push_exp(48'h48000001AA87, RETRIES + 1, 0, 0, 1, 1, 128'h1AA, 6'd8, -1);
        run_cmd(6'd8, 32'h1AA, 2'd1);

        f41 = mk_frame(6'd41, 32'h40FF8000);
        set_card('0, 0, 1, 0);
        push_exp(f41, RETRIES + 1, 0, 1, 0, 0, '0, 6'd0, NCR_MAX + GAP);
        run_cmd(6'd41, 32'h40FF8000, 2'd2);

        set_card({88'b0, 48'h3F00FF8000FF}, 48, 2, 2);
        push_exp(f41, 2, 1, 0, 0, 1, 128'h00FF8000, 6'h3F, -1);
        run_cmd(6'd41, 32'h40FF8000, 2'd2);

        f2      = mk_frame(6'd2, 32'h0);
        cid     = 120'h0353445344313280_1234567890ABCD;
        cid_crc = crc7(cid, 120);
        r2      = {2'b00, 6'b111111, cid, cid_crc, 1'b1};
        set_card(r2, 136, 1, 3);
        push_exp(f2, 1, 1, 0, 0, 1, {cid, cid_crc, 1'b0}, 6'd0, -1);
        run_cmd(6'd2, 32'h0, 2'd3);

        set_card(r2, 136, 1, 3);
        @(posedge iclk);
        #1;
        iindex     = 6'd2;
        iarg       = 32'h0;
        iresp_type = 2'd3;
        istart     = 1'b1;
        @(posedge iclk);
        #1;
        istart = 1'b0;
        n = 0;
        while (card_bits < 60 && n < 20000) begin
            @(posedge iclk);
            #1;
            n++;
        end
        check("reached_recv", (card_bits >= 60), 1);
        irst = 1'b1;
        #1;
        chk_reset_outs("abort");
        repeat (30) @(posedge iclk);
        #1;
        irst = 1'b0;
        txq.delete();
        repeat (2) @(posedge iclk);

        set_card('0, 0, 1, 0);
        push_exp(48'h400000000095, 1, 1, 0, 0, 1, '0, 6'd0, GAP);
        run_cmd(6'd0, 32'h0, 2'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
